imm_pixel_scanner: RTL and testbench

- Upstream feeder for the image-masking stage.
- On start, raster-scans one frame stored in a synchronous frame-buffer BRAM, issuing reads and absorbing the fixed BRAM read latency.
- Presents each pixel with its row/col coordinates and the frame-stable mask offsets, under a valid/ready handshake.
- Guarantees the masking stage sees every pixel exactly once, in raster order, with offsets constant for the whole frame.

---
 rtl/imm_pixel_scanner.sv | 240 ++++++++++++++++++++++++
 tb/tb_imm_pixel_scanner.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_pixel_scanner.sv
// imm_pixel_scanner: raster-scans one frame out of a synchronous frame-buffer
// BRAM and feeds the image-masking stage. Each pixel goes out with its row/col
// and the frame-stable mask offsets under a valid/ready handshake. A read is
// only issued when it has a guaranteed slot in the output FIFO, so the
// fixed-latency BRAM can never overrun the buffer.
module imm_pixel_scanner #(
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int PIXEL_WIDTH = 12,
  parameter int ADDR_WIDTH  = 17,
  parameter int RAM_LATENCY = 1,
  parameter int FIFO_DEPTH  = RAM_LATENCY + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             mask_row_offset_in,
  input  logic [8:0]             mask_col_offset_in,
  output logic                   fb_rd_en,
  output logic [ADDR_WIDTH-1:0]  fb_rd_addr,
  input  logic [PIXEL_WIDTH-1:0] fb_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] image_pixel,
  output logic [7:0]             pixel_row,
  output logic [8:0]             pixel_col,
  output logic [7:0]             mask_row_offset,
  output logic [8:0]             mask_col_offset,
  output logic                   busy,
  output logic                   done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [7:0]            LAST_ROW = 8'(IMG_HEIGHT - 1);
  localparam logic [8:0]            LAST_COL = 9'(IMG_WIDTH - 1);
  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Next pixel to be requested, and the tags of the read on the bus now.
  logic [7:0]            next_row;
  logic [8:0]            next_col;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [7:0]            tag_row;
  logic [8:0]            tag_col;

  // In-flight tracker: one stage per cycle of BRAM latency.
  logic       pipe_vld [RAM_LATENCY];
  logic [7:0] pipe_row [RAM_LATENCY];
  logic [8:0] pipe_col [RAM_LATENCY];

  // First-word-fall-through output FIFO.
  logic [PIXEL_WIDTH-1:0] mem_pix [FIFO_DEPTH];
  logic [7:0]             mem_row [FIFO_DEPTH];
  logic [8:0]             mem_col [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;

  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      fifo_cnt_next;
  logic [CNT_W-1:0]      infl_next;
  logic                  credit_ok;
  logic                  start_ok;
  logic                  issue;
  logic [7:0]            cur_row;
  logic [8:0]            cur_col;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  is_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_ONE;
    end
  endfunction

  // Credit check and issue decision, made on next-cycle occupancy so that a
  // read launched next cycle always has a FIFO slot reserved for it.
  always_comb begin
    push = pipe_vld[RAM_LATENCY-1];
    pop  = out_valid && out_ready;
    fifo_cnt_next = fifo_cnt;
    if (push && !pop) begin
      fifo_cnt_next = fifo_cnt + CNT_ONE;
    end else if (!push && pop) begin
      fifo_cnt_next = fifo_cnt - CNT_ONE;
    end else begin
      fifo_cnt_next = fifo_cnt;
    end
    // The read on the bus now plus every stage that is not leaving this cycle.
    infl_next = {{(CNT_W-1){1'b0}}, fb_rd_en};
    for (int k = 0; k < RAM_LATENCY - 1; k++) begin
      infl_next = infl_next + {{(CNT_W-1){1'b0}}, pipe_vld[k]};
    end
    credit_ok = (fifo_cnt_next + infl_next) < DEPTH_C;
    start_ok  = (state == IDLE) && start;
    if (start_ok) begin
      cur_row  = 8'd0;
      cur_col  = 9'd0;
      cur_addr = {ADDR_WIDTH{1'b0}};
    end else begin
      cur_row  = next_row;
      cur_col  = next_col;
      cur_addr = next_addr;
    end
    is_last = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
    issue   = start_ok || ((state == SCAN) && credit_ok);
  end

  // Frame control FSM with registered read strobe, status and offsets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      fb_rd_en        <= 1'b0;
      fb_rd_addr      <= {ADDR_WIDTH{1'b0}};
      next_addr       <= {ADDR_WIDTH{1'b0}};
      next_row        <= 8'd0;
      next_col        <= 9'd0;
      tag_row         <= 8'd0;
      tag_col         <= 9'd0;
      mask_row_offset <= 8'd0;
      mask_col_offset <= 9'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      fb_rd_en <= 1'b0;
      done     <= 1'b0;
      if (issue) begin
        fb_rd_en   <= 1'b1;
        fb_rd_addr <= cur_addr;
        tag_row    <= cur_row;
        tag_col    <= cur_col;
        next_addr  <= cur_addr + ADDR_ONE;
        if (cur_col == LAST_COL) begin
          next_col <= 9'd0;
          next_row <= cur_row + 8'd1;
        end else begin
          next_col <= cur_col + 9'd1;
          next_row <= cur_row;
        end
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            mask_row_offset <= mask_row_offset_in;
            mask_col_offset <= mask_col_offset_in;
            busy            <= 1'b1;
            state           <= is_last ? DRAIN : SCAN;
          end
        end
        SCAN: begin
          if (issue && is_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((infl_next == CNT_ZERO) && (fifo_cnt_next == CNT_ZERO)) begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // In-flight tracker: tags ride alongside the BRAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RAM_LATENCY; k++) begin
        pipe_vld[k] <= 1'b0;
        pipe_row[k] <= 8'd0;
        pipe_col[k] <= 9'd0;
      end
    end else begin
      pipe_vld[0] <= fb_rd_en;
      pipe_row[0] <= tag_row;
      pipe_col[0] <= tag_col;
      for (int k = 1; k < RAM_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_row[k] <= pipe_row[k-1];
        pipe_col[k] <= pipe_col[k-1];
      end
    end
  end

  // Output FIFO: returning data is written with its tags, head pops on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= {PTR_W{1'b0}};
      rd_ptr    <= {PTR_W{1'b0}};
      fifo_cnt  <= CNT_ZERO;
      out_valid <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_pix[k] <= {PIXEL_WIDTH{1'b0}};
        mem_row[k] <= 8'd0;
        mem_col[k] <= 9'd0;
      end
    end else begin
      if (push) begin
        mem_pix[wr_ptr] <= fb_rd_data;
        mem_row[wr_ptr] <= pipe_row[RAM_LATENCY-1];
        mem_col[wr_ptr] <= pipe_col[RAM_LATENCY-1];
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      fifo_cnt  <= fifo_cnt_next;
      out_valid <= (fifo_cnt_next != CNT_ZERO);
    end
  end

  assign image_pixel = mem_pix[rd_ptr];
  assign pixel_row   = mem_row[rd_ptr];
  assign pixel_col   = mem_col[rd_ptr];

endmodule

// File: tb/tb_imm_pixel_scanner.sv
// Bench for imm_pixel_scanner: a small 4x3 instance (latency 1) and a full
// 320x240 instance (latency 3), each fed by a BRAM model and checked beat by
// beat against a raster-order reference (beat k -> row k/W, col k%W).
`timescale 1ns/1ps
module tb_imm_pixel_scanner;

  localparam int AW = 4;
  localparam int AH = 3;
  localparam int AL = 1;
  localparam int AN = AW * AH;
  localparam int BW = 320;
  localparam int BH = 240;
  localparam int BL = 3;
  localparam int BN = BW * BH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A signals ----------------
  logic        a_start = 1'b0;
  logic [7:0]  a_mro_in = 8'd0;
  logic [8:0]  a_mco_in = 9'd0;
  logic        a_en;
  logic [16:0] a_addr;
  logic [11:0] a_rdata = 12'd0;
  logic        a_valid;
  logic        a_ready = 1'b1;
  logic [11:0] a_pix;
  logic [7:0]  a_row, a_mro;
  logic [8:0]  a_col, a_mco;
  logic        a_busy, a_done;

  // ---------------- instance B signals ----------------
  logic        b_start = 1'b0;
  logic [7:0]  b_mro_in = 8'd0;
  logic [8:0]  b_mco_in = 9'd0;
  logic        b_en;
  logic [16:0] b_addr;
  logic [11:0] b_d1 = 12'd0, b_d2 = 12'd0, b_rdata = 12'd0;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [11:0] b_pix;
  logic [7:0]  b_row, b_mro;
  logic [8:0]  b_col, b_mco;
  logic        b_busy, b_done;

  imm_pixel_scanner #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH), .PIXEL_WIDTH(12),
                      .ADDR_WIDTH(17), .RAM_LATENCY(AL)) u_a (
    .clk(clk), .rst(rst), .start(a_start),
    .mask_row_offset_in(a_mro_in), .mask_col_offset_in(a_mco_in),
    .fb_rd_en(a_en), .fb_rd_addr(a_addr), .fb_rd_data(a_rdata),
    .out_valid(a_valid), .out_ready(a_ready), .image_pixel(a_pix),
    .pixel_row(a_row), .pixel_col(a_col),
    .mask_row_offset(a_mro), .mask_col_offset(a_mco),
    .busy(a_busy), .done(a_done));

  imm_pixel_scanner #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .PIXEL_WIDTH(12),
                      .ADDR_WIDTH(17), .RAM_LATENCY(BL)) u_b (
    .clk(clk), .rst(rst), .start(b_start),
    .mask_row_offset_in(b_mro_in), .mask_col_offset_in(b_mco_in),
    .fb_rd_en(b_en), .fb_rd_addr(b_addr), .fb_rd_data(b_rdata),
    .out_valid(b_valid), .out_ready(b_ready), .image_pixel(b_pix),
    .pixel_row(b_row), .pixel_col(b_col),
    .mask_row_offset(b_mro), .mask_col_offset(b_mco),
    .busy(b_busy), .done(b_done));

  // Frame-buffer contents: a scrambled function of the address.
  function automatic logic [11:0] pix_of(input int a);
    int v;
    v = (a * 5) ^ (a >> 7);
    return v[11:0];
  endfunction

  // BRAM models: latency 1 for A, latency 3 for B.
  always @(posedge clk) begin
    if (a_en) a_rdata <= pix_of(int'(a_addr));
    if (b_en) b_d1 <= pix_of(int'(b_addr));
    b_d2    <= b_d1;
    b_rdata <= b_d2;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference state for A ----------------
  int a_idx = AN;            // next expected beat index; AN means no frame armed
  int a_exp_mro = 0, a_exp_mco = 0;
  int a_first_rd = -1, a_first_valid = -1, a_last_beat = -1, a_done_cyc = -1;
  int a_done_cnt = 0, a_issued = 0, a_popped = 0;
  int a_rmode = 0, a_pidx = 0;

  task automatic arm_a(input int r, input int c);
    a_idx = 0; a_exp_mro = r; a_exp_mco = c;
    a_first_rd = -1; a_first_valid = -1; a_last_beat = -1; a_done_cyc = -1;
    a_done_cnt = 0; a_issued = 0; a_popped = 0;
  endtask

  task automatic start_a(input int r, input int c, output int s);
    a_mro_in = 8'(r); a_mco_in = 9'(c); a_start = 1'b1;
    arm_a(r, c);
    s = cyc;
    tick(1);
    a_start = 1'b0;
  endtask

  task automatic wait_a_done(input int budget);
    int n;
    n = 0;
    while (a_done_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    check("a_done_timeout", int'(a_done_cnt != 0), 1);
    tick(3);
    check("a_done_once", a_done_cnt, 1);
    check("a_reads_per_frame", a_issued, AN);
    check("a_beats_per_frame", a_idx, AN);
  endtask

  // Ready driver for A: always-on, 1,0,0,1 pattern, or random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (a_rmode)
        0: a_ready = 1'b1;
        1: begin
          a_ready = ((a_pidx % 4) == 0) || ((a_pidx % 4) == 3);
          a_pidx++;
        end
        default: a_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor A: every valid cycle is compared with the expected head beat.
  initial begin
    forever begin
      @(negedge clk);
      if (a_en) begin
        a_issued++;
        if (a_first_rd < 0) a_first_rd = cyc;
        check("a_outstanding", int'((a_issued - a_popped) <= AL + 2), 1);
      end
      if (a_valid) begin
        if (a_idx < AN) begin
          check("a_row", int'(a_row), a_idx / AW);
          check("a_col", int'(a_col), a_idx % AW);
          check("a_pix", int'(a_pix), int'(pix_of(a_idx)));
          check("a_mro", int'(a_mro), a_exp_mro);
          check("a_mco", int'(a_mco), a_exp_mco);
          if (a_first_valid < 0) a_first_valid = cyc;
          if (a_ready) begin
            a_idx++;
            a_popped++;
            a_last_beat = cyc;
          end
        end else begin
          check("a_spurious_valid", int'(a_valid), 0);
        end
      end
      if (a_done) begin
        a_done_cnt++;
        a_done_cyc = cyc;
        check("a_done_after_all", a_idx, AN);
        check("a_busy_at_done", int'(a_busy), 0);
      end
    end
  end

  // ---------------- reference state for B ----------------
  int b_idx = BN;
  int b_exp_mro = 0, b_exp_mco = 0;
  int b_issued = 0, b_last_addr = -1, b_last_row = -1, b_last_col = -1, b_done_cnt = 0;

  // Monitor B.
  initial begin
    forever begin
      @(negedge clk);
      if (b_en) begin
        b_issued++;
        b_last_addr = int'(b_addr);
      end
      if (b_valid) begin
        if (b_idx < BN) begin
          check("b_row", int'(b_row), b_idx / BW);
          check("b_col", int'(b_col), b_idx % BW);
          check("b_pix", int'(b_pix), int'(pix_of(b_idx)));
          check("b_offsets", {23'd0, b_mco} * 256 + int'(b_mro), b_exp_mco * 256 + b_exp_mro);
          if (b_ready) begin
            b_last_row = int'(b_row);
            b_last_col = int'(b_col);
            b_idx++;
          end
        end else begin
          check("b_spurious_valid", int'(b_valid), 0);
        end
      end
      if (b_done) begin
        b_done_cnt++;
        check("b_done_after_all", b_idx, BN);
      end
    end
  end

  task automatic check_a_zero(input string pfx);
    check({pfx, "_rd_en"}, int'(a_en), 0);
    check({pfx, "_rd_addr"}, int'(a_addr), 0);
    check({pfx, "_valid"}, int'(a_valid), 0);
    check({pfx, "_busy"}, int'(a_busy), 0);
    check({pfx, "_done"}, int'(a_done), 0);
    check({pfx, "_pix"}, int'(a_pix), 0);
    check({pfx, "_row"}, int'(a_row), 0);
    check({pfx, "_col"}, int'(a_col), 0);
    check({pfx, "_mro"}, int'(a_mro), 0);
    check({pfx, "_mco"}, int'(a_mco), 0);
  endtask

  initial begin
    int s, r, c, n;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Reset state.
    check_a_zero("rst");
    check("rst_b_valid", int'(b_valid), 0);
    check("rst_b_busy", int'(b_busy), 0);

    // Frame 1: ready always high, exact cycle timing.
    a_rmode = 0;
    tick(1);
    r = int'($urandom_range(0, 255));
    c = int'($urandom_range(0, 511));
    start_a(r, c, s);
    check("a_busy_after_start", int'(a_busy), 1);
    while (cyc < s + 15) tick(1);
    // Start in the DONE cycle is ignored, start in the done cycle is taken.
    r = int'($urandom_range(0, 255));
    c = int'($urandom_range(0, 511));
    a_mro_in = 8'(r); a_mco_in = 9'(c); a_start = 1'b1;
    tick(1);
    check("a_busy_in_done_cycle", int'(a_busy), 0);
    check("a_done_pulse", int'(a_done), 1);
    tick(1);
    a_start = 1'b0;
    check("a_first_rd_lat", a_first_rd, s + 1);
    check("a_first_valid_lat", a_first_valid, s + 1 + AL + 1);
    check("a_last_beat_cyc", a_last_beat, s + AN + AL + 1);
    check("a_done_cyc", a_done_cyc, s + AN + AL + 3);
    check("a_done_once_f1", a_done_cnt, 1);
    check("a_reads_f1", a_issued, AN);
    check("a_beats_f1", a_idx, AN);
    check("a_restart_rd", int'(a_en), 1);
    check("a_restart_addr", int'(a_addr), 0);
    check("a_restart_busy", int'(a_busy), 1);
    arm_a(r, c);

    // Frame 2 (already running): ready pattern 1,0,0,1.
    a_pidx = 0;
    a_rmode = 1;
    wait_a_done(200);

    // Frame 3: random ready, offsets 5/9, inputs cleared and start pulsed mid-frame.
    a_rmode = 2;
    tick(1);
    start_a(5, 9, s);
    tick(4);
    a_mro_in = 8'd0; a_mco_in = 9'd0; a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
    wait_a_done(300);

    // Frame 4: async reset while pixel 6 is being read.
    tick(1);
    start_a(int'($urandom_range(0, 255)), int'($urandom_range(0, 511)), s);
    n = 0;
    while (!(a_en && (a_addr == 17'd6)) && n < 200) begin
      tick(1);
      n++;
    end
    check("a_reach_pixel6", int'(a_en && (a_addr == 17'd6)), 1);
    a_idx = AN;
    #2 rst = 1'b1;
    #1 check_a_zero("midrst");
    tick(3);
    rst = 1'b0;
    a_issued = 0;
    a_rmode = 0;
    tick(10);
    check("a_no_reads_after_rst", a_issued, 0);
    check("a_idle_after_rst", int'(a_busy), 0);

    // Frame 5: restarts from (0,0), random ready.
    a_rmode = 2;
    start_a(int'($urandom_range(0, 255)), int'($urandom_range(0, 511)), s);
    wait_a_done(300);

    // Full frame on B: hold ready low for 20 cycles after start.
    b_ready = 1'b0;
    b_exp_mro = int'($urandom_range(0, 255));
    b_exp_mco = int'($urandom_range(0, 511));
    b_mro_in = 8'(b_exp_mro); b_mco_in = 9'(b_exp_mco); b_start = 1'b1;
    b_idx = 0; b_issued = 0; b_done_cnt = 0;
    s = cyc;
    tick(1);
    b_start = 1'b0;
    b_mro_in = 8'd0; b_mco_in = 9'd0;
    while (cyc < s + 20) tick(1);
    check("b_stall_reads", b_issued, BL + 2);
    check("b_stall_rd_en", int'(b_en), 0);
    check("b_stall_valid", int'(b_valid), 1);
    check("b_stall_no_pop", b_idx, 0);
    b_ready = 1'b1;
    n = 0;
    while (b_done_cnt == 0 && n < BN + 200) begin
      tick(1);
      n++;
    end
    check("b_done_timeout", int'(b_done_cnt != 0), 1);
    tick(3);
    check("b_done_once", b_done_cnt, 1);
    check("b_reads", b_issued, BN);
    check("b_beats", b_idx, BN);
    check("b_last_addr", b_last_addr, BN - 1);
    check("b_last_row", b_last_row, BH - 1);
    check("b_last_col", b_last_col, BW - 1);
    check("b_busy_end", int'(b_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
